// File: rtl/karatsuba_pkg.sv
// Shared types and helpers for the sequential Karatsuba multiplier.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    ADD  = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w % 2 == 0);
  endfunction

endpackage

// File: rtl/karatsuba_half_mul.sv
// Combinational (H+1)x(H+1) unsigned multiplier shared by all product states.
module karatsuba_half_mul #(
  parameter int H = 32
) (
  input  logic [H:0]     a,
  input  logic [H:0]     b,
  output logic [2*H+1:0] p
);

  assign p = {{(H+1){1'b0}}, a} * {{(H+1){1'b0}}, b};

endmodule

// File: rtl/karatsuba_seq.sv
// One-level Karatsuba multiplier reusing a single half-width multiplier
// across LO, HI and MID states, with valid/ready on both sides.
module karatsuba_seq
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     Xin,
  input  logic [WIDTH-1:0]     Yin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic [WIDTH-1:0]     high,
  output logic [WIDTH-1:0]     low,
  output logic [WIDTH:0]       mid
);

  localparam int H = half_w(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("karatsuba_seq: WIDTH must be even and >= 4");
  end

  state_t             state;
  logic [WIDTH-1:0]   xr, yr;
  logic [H-1:0]       xh, xl, yh, yl;
  logic [H:0]         ma, mb;
  logic [2*H+1:0]     mp;
  logic [2*H+1:0]     msum;
  logic [WIDTH+1:0]   mfull;
  logic [WIDTH:0]     mid_c;
  logic [2*WIDTH-1:0] p_c;
  logic               unused_msb;

  assign xh = xr[WIDTH-1:H];
  assign xl = xr[H-1:0];
  assign yh = yr[WIDTH-1:H];
  assign yl = yr[H-1:0];

  assign in_ready = (state == IDLE);

  // Half sums keep their carry: H+1 bits into the shared multiplier.
  always_comb begin
    ma = '0;
    mb = '0;
    unique case (1'b1)
      state == LO: begin
        ma = {1'b0, xl};
        mb = {1'b0, yl};
      end
      state == HI: begin
        ma = {1'b0, xh};
        mb = {1'b0, yh};
      end
      state == MID: begin
        ma = {1'b0, xh} + {1'b0, xl};
        mb = {1'b0, yh} + {1'b0, yl};
      end
      default: ;
    endcase
  end

  karatsuba_half_mul #(
    .H (H)
  ) u_mul (
    .a (ma),
    .b (mb),
    .p (mp)
  );

  // The cross term always fits WIDTH+1 bits, so the top bit is dropped.
  assign mfull      = msum - {2'b00, high} - {2'b00, low};
  assign mid_c      = mfull[WIDTH:0];
  assign unused_msb = mfull[WIDTH+1];

  assign p_c = {high, low}
             + {{(WIDTH-H-1){1'b0}}, mid_c, {H{1'b0}}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      low       <= '0;
      high      <= '0;
      msum      <= '0;
      mid       <= '0;
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= Xin;
            yr    <= Yin;
            state <= LO;
          end
        end
        LO: begin
          low   <= mp[WIDTH-1:0];
          state <= HI;
        end
        HI: begin
          high  <= mp[WIDTH-1:0];
          state <= MID;
        end
        MID: begin
          msum  <= mp;
          state <= ADD;
        end
        ADD: begin
          mid       <= mid_c;
          P         <= p_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
